// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide unit for the RV64M ops.
// It sits beside the single-cycle ALU in EX. An op is taken through a
// valid/ready handshake, the pipe is stalled through busy_o while the op
// iterates (one bit per cycle), and the 64-bit result is returned through a
// second valid/ready handshake.
//
// Ports
//   clock     in   1   clock, all state on posedge
//   reset     in   1   asynchronous active-low reset
//   valid_i   in   1   op request from EX
//   ready_o   out  1   unit can accept an op (IDLE)
//   aluop_i   in   5   ALU op code, only M-extension codes are accepted
//   srcA_i    in  64   rs1 value
//   srcB_i    in  64   rs2 value
//   rd_i      in   5   destination register, carried to rd_o
//   flush_i   in   1   abort in-flight op, wins over every handshake
//   valid_o   out  1   result available (DONE)
//   ready_i   in   1   consumer takes the result
//   result_o  out 64   final result
//   rd_o      out  5   destination register of result_o
//   busy_o    out  1   unit not IDLE, stall for ID/IF
module muldiv_iter #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  aluop_i,
  input  logic [63:0] srcA_i,
  input  logic [63:0] srcB_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] result_o,
  output logic [4:0]  rd_o,
  output logic        busy_o
);

  // M-extension op codes as emitted by decode
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam logic [4:0] ALU_MULW   = 5'd24;
  localparam logic [4:0] ALU_DIVW   = 5'd25;
  localparam logic [4:0] ALU_DIVUW  = 5'd26;
  localparam logic [4:0] ALU_REMW   = 5'd27;
  localparam logic [4:0] ALU_REMUW  = 5'd28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // latched op context
  logic [6:0]   r_cnt;
  logic [4:0]   r_op;
  logic         r_is_w;
  logic         r_sa;
  logic         r_sb;
  logic         r_divzero;
  logic [4:0]   r_rd;
  // multiplicand / divisor magnitude
  logic [63:0]  r_opb;
  // {high, low} shift-add accumulator; low half starts as the multiplier
  logic [127:0] r_acc;
  // dividend shifts out of r_quo as quotient bits shift in
  logic [63:0]  r_quo;
  logic [63:0]  r_rem;
  logic [63:0]  r_result;
  logic [4:0]   r_rd_o;

  // entry decode
  logic         w_is_m;
  logic         w_is_w;
  logic         w_is_div;
  logic         w_sgn_a_op;
  logic         w_sgn_b_op;
  logic         w_sa;
  logic         w_sb;
  logic         w_divzero;
  logic         w_ovf;
  logic         w_early;
  logic         w_accept;
  logic [63:0]  w_a_mag;
  logic [63:0]  w_b_mag;

  // iteration step
  logic         w_cnt_zero;
  logic [64:0]  w_mul_sum;
  logic [64:0]  w_rem_sh;
  logic [63:0]  w_sub;
  logic         w_ge;

  // final sign/selection
  logic [127:0] w_prod;
  logic [127:0] w_prod_s;
  logic [63:0]  w_quo_v;
  logic [63:0]  w_quo_s;
  logic [63:0]  w_rem_s;
  logic [63:0]  w_final;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    sext32 = {{32{x[31]}}, x};
  endfunction

  // Classify the incoming op and form operand magnitudes.
  always_comb begin
    w_is_m     = 1'b1;
    w_is_w     = 1'b0;
    w_is_div   = 1'b0;
    w_sgn_a_op = 1'b0;
    w_sgn_b_op = 1'b0;
    case (aluop_i)
      ALU_MUL:    begin end
      ALU_MULH:   begin w_sgn_a_op = 1'b1; w_sgn_b_op = 1'b1; end
      ALU_MULHSU: begin w_sgn_a_op = 1'b1; end
      ALU_MULHU:  begin end
      ALU_DIV:    begin w_is_div = 1'b1; w_sgn_a_op = 1'b1; w_sgn_b_op = 1'b1; end
      ALU_DIVU:   begin w_is_div = 1'b1; end
      ALU_REM:    begin w_is_div = 1'b1; w_sgn_a_op = 1'b1; w_sgn_b_op = 1'b1; end
      ALU_REMU:   begin w_is_div = 1'b1; end
      ALU_MULW:   begin w_is_w = 1'b1; end
      ALU_DIVW:   begin w_is_w = 1'b1; w_is_div = 1'b1; w_sgn_a_op = 1'b1; w_sgn_b_op = 1'b1; end
      ALU_DIVUW:  begin w_is_w = 1'b1; w_is_div = 1'b1; end
      ALU_REMW:   begin w_is_w = 1'b1; w_is_div = 1'b1; w_sgn_a_op = 1'b1; w_sgn_b_op = 1'b1; end
      ALU_REMUW:  begin w_is_w = 1'b1; w_is_div = 1'b1; end
      default:    begin w_is_m = 1'b0; end
    endcase

    if (w_is_w) begin
      w_sa    = w_sgn_a_op & srcA_i[31];
      w_sb    = w_sgn_b_op & srcB_i[31];
      w_a_mag = w_sa ? {32'd0, (~srcA_i[31:0] + 32'd1)} : {32'd0, srcA_i[31:0]};
      w_b_mag = w_sb ? {32'd0, (~srcB_i[31:0] + 32'd1)} : {32'd0, srcB_i[31:0]};
      w_divzero = w_is_div & (srcB_i[31:0] == 32'd0);
      w_ovf     = w_is_div & w_sgn_a_op & (srcA_i[31:0] == 32'h8000_0000) &
                  (srcB_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_sa    = w_sgn_a_op & srcA_i[63];
      w_sb    = w_sgn_b_op & srcB_i[63];
      w_a_mag = w_sa ? (~srcA_i + 64'd1) : srcA_i;
      w_b_mag = w_sb ? (~srcB_i + 64'd1) : srcB_i;
      w_divzero = w_is_div & (srcB_i == 64'd0);
      w_ovf     = w_is_div & w_sgn_a_op & (srcA_i == 64'h8000_0000_0000_0000) &
                  (srcB_i == 64'hFFFF_FFFF_FFFF_FFFF);
    end

    w_early  = EARLY_OUT & (w_divzero | w_ovf);
    // flush beats a request arriving in IDLE
    w_accept = valid_i & (r_state == S_IDLE) & ~flush_i & w_is_m;
  end

  // One shift-add and one restoring shift-subtract step.
  always_comb begin
    w_cnt_zero = (r_cnt == 7'd0);
    w_mul_sum  = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_opb} : 65'd0);
    w_rem_sh   = {r_rem, r_quo[63]};
    w_ge       = (w_rem_sh >= {1'b0, r_opb});
    // when w_ge the true difference is below the divisor, so 64 bits suffice
    w_sub      = w_rem_sh[63:0] - r_opb;
  end

  // Apply final signs and select the architectural result.
  always_comb begin
    // a 32-iteration multiply leaves the product 32 bits up in the accumulator
    w_prod   = r_is_w ? {32'd0, r_acc[127:32]} : r_acc;
    w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 128'd1) : w_prod;
    w_quo_v  = r_is_w ? {32'd0, r_quo[31:0]} : r_quo;
    // all-ones quotient of a divide by zero keeps its value regardless of sign
    w_quo_s  = ((r_sa ^ r_sb) & ~r_divzero) ? (~w_quo_v + 64'd1) : w_quo_v;
    w_rem_s  = r_sa ? (~r_rem + 64'd1) : r_rem;
    case (r_op)
      ALU_MUL:    w_final = w_prod_s[63:0];
      ALU_MULH:   w_final = w_prod_s[127:64];
      ALU_MULHSU: w_final = w_prod_s[127:64];
      ALU_MULHU:  w_final = w_prod_s[127:64];
      ALU_DIV:    w_final = w_quo_s;
      ALU_DIVU:   w_final = w_quo_s;
      ALU_REM:    w_final = w_rem_s;
      ALU_REMU:   w_final = w_rem_s;
      ALU_MULW:   w_final = sext32(w_prod_s[31:0]);
      ALU_DIVW:   w_final = sext32(w_quo_s[31:0]);
      ALU_DIVUW:  w_final = sext32(w_quo_s[31:0]);
      ALU_REMW:   w_final = sext32(w_rem_s[31:0]);
      ALU_REMUW:  w_final = sext32(w_rem_s[31:0]);
      default:    w_final = 64'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_is_div ? S_DIV : S_MUL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (flush_i) begin
          w_next_state = S_IDLE;
        end else if (w_cnt_zero) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = r_state;
        end
      end
      S_DONE: begin
        if (flush_i || ready_i) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch and per-cycle iteration.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= 7'd0;
      r_op      <= 5'd0;
      r_is_w    <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_divzero <= 1'b0;
      r_rd      <= 5'd0;
      r_opb     <= 64'd0;
      r_acc     <= 128'd0;
      r_quo     <= 64'd0;
      r_rem     <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= aluop_i;
            r_is_w    <= w_is_w;
            r_sa      <= w_sa;
            r_sb      <= w_sb;
            r_divzero <= w_divzero;
            r_rd      <= rd_i;
            r_opb     <= w_b_mag;
            r_acc     <= {64'd0, w_a_mag};
            if (w_early) begin
              // zero iterations: preload the magnitudes the full run would reach
              r_cnt <= 7'd0;
              if (w_divzero) begin
                r_quo <= w_is_w ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
                r_rem <= w_a_mag;
              end else begin
                r_quo <= w_is_w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                r_rem <= 64'd0;
              end
            end else begin
              r_cnt <= w_is_w ? 7'd32 : 7'd64;
              // W dividend sits in the top half so its MSB shifts out first
              r_quo <= w_is_w ? {w_a_mag[31:0], 32'd0} : w_a_mag;
              r_rem <= 64'd0;
            end
          end
        end
        S_MUL: begin
          if (!w_cnt_zero) begin
            r_acc <= {w_mul_sum, r_acc[63:1]};
            r_cnt <= r_cnt - 7'd1;
          end
        end
        S_DIV: begin
          if (!w_cnt_zero) begin
            r_rem <= w_ge ? w_sub : w_rem_sh[63:0];
            r_quo <= {r_quo[62:0], w_ge};
            r_cnt <= r_cnt - 7'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers, written once on the way into DONE and held after.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result <= 64'd0;
      r_rd_o   <= 5'd0;
    end else if ((r_state == S_MUL || r_state == S_DIV) && w_cnt_zero && !flush_i) begin
      r_result <= w_final;
      r_rd_o   <= r_rd;
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;
  assign rd_o     = r_rd_o;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: self-checking bench for muldiv_iter. Two instances run side
// by side, one with EARLY_OUT=1 (index 0) and one with EARLY_OUT=0 (index 1).
// A reference model computes each result with plain wide arithmetic and the
// acceptance-to-valid latency from the op width; a compare process checks
// handshake flags, result and rd on every falling edge.
`timescale 1ns/1ps
module tb_muldiv_iter;

  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;
  localparam logic [4:0] OP_MULW   = 5'd24;
  localparam logic [4:0] OP_DIVW   = 5'd25;
  localparam logic [4:0] OP_DIVUW  = 5'd26;
  localparam logic [4:0] OP_REMW   = 5'd27;
  localparam logic [4:0] OP_REMUW  = 5'd28;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_i[2];
  logic        rdy_o[2];
  logic [4:0]  op_i[2];
  logic [63:0] a_i[2];
  logic [63:0] b_i[2];
  logic [4:0]  rd_in[2];
  logic        fl_i[2];
  logic        v_o[2];
  logic        rdy_i[2];
  logic [63:0] res_o[2];
  logic [4:0]  rd_out[2];
  logic        bsy_o[2];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          exp_active[2];
  logic [63:0] exp_res[2];
  logic [4:0]  exp_rd[2];
  int          exp_vcyc[2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter #(.EARLY_OUT(1'b1)) u_dut_eo (
    .clock(clk), .reset(rst_n), .valid_i(v_i[0]), .ready_o(rdy_o[0]),
    .aluop_i(op_i[0]), .srcA_i(a_i[0]), .srcB_i(b_i[0]), .rd_i(rd_in[0]),
    .flush_i(fl_i[0]), .valid_o(v_o[0]), .ready_i(rdy_i[0]),
    .result_o(res_o[0]), .rd_o(rd_out[0]), .busy_o(bsy_o[0])
  );

  muldiv_iter #(.EARLY_OUT(1'b0)) u_dut_full (
    .clock(clk), .reset(rst_n), .valid_i(v_i[1]), .ready_o(rdy_o[1]),
    .aluop_i(op_i[1]), .srcA_i(a_i[1]), .srcB_i(b_i[1]), .rd_i(rd_in[1]),
    .flush_i(fl_i[1]), .valid_o(v_o[1]), .ready_i(rdy_i[1]),
    .result_o(res_o[1]), .rd_o(rd_out[1]), .busy_o(bsy_o[1])
  );

  task automatic chk(input string nm, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h time=%0t", nm, inst, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] x);
    sx = {{32{x[31]}}, x};
  endfunction

  // Reference result from the RV64M definitions.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    model = 64'd0;
    r32 = 32'd0;
    p = 128'd0;
    case (op)
      OP_MUL:    begin p = {64'd0, a} * {64'd0, b}; model = p[63:0]; end
      OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; model = p[127:64]; end
      OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'd0, b}; model = p[127:64]; end
      OP_MULHU:  begin p = {64'd0, a} * {64'd0, b}; model = p[127:64]; end
      OP_DIV:    model = (b == 64'd0) ? ONES64 : ((a == MIN64 && b == ONES64) ? a : 64'(sa / sb));
      OP_DIVU:   model = (b == 64'd0) ? ONES64 : a / b;
      OP_REM:    model = (b == 64'd0) ? a : ((a == MIN64 && b == ONES64) ? 64'd0 : 64'(sa % sb));
      OP_REMU:   model = (b == 64'd0) ? a : a % b;
      OP_MULW:   begin r32 = a32 * b32; model = sx(r32); end
      OP_DIVW:   begin
        r32 = (b32 == 32'd0) ? 32'hFFFF_FFFF :
              ((a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? a32 : 32'(sa32 / sb32));
        model = sx(r32);
      end
      OP_DIVUW:  begin r32 = (b32 == 32'd0) ? 32'hFFFF_FFFF : a32 / b32; model = sx(r32); end
      OP_REMW:   begin
        r32 = (b32 == 32'd0) ? a32 :
              ((a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa32 % sb32));
        model = sx(r32);
      end
      OP_REMUW:  begin r32 = (b32 == 32'd0) ? a32 : a32 % b32; model = sx(r32); end
      default:   model = 64'd0;
    endcase
  endfunction

  // Edges from acceptance to the edge after which valid_o is high: K+1, or 1 for early-out.
  function automatic int lat_of(input int inst, input logic [4:0] op, input logic [63:0] a,
                                input logic [63:0] b);
    bit w;
    bit d;
    bit dz;
    bit ov;
    w  = (op == OP_MULW || op == OP_DIVW || op == OP_DIVUW || op == OP_REMW || op == OP_REMUW);
    d  = (op >= OP_DIV && op <= OP_REMU) || (op >= OP_DIVW && op <= OP_REMUW);
    dz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = ((op == OP_DIV || op == OP_REM) && a == MIN64 && b == ONES64) ||
         ((op == OP_DIVW || op == OP_REMW) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    if (inst == 0 && d && (dz || ov)) return 1;
    return w ? 33 : 65;
  endfunction

  // Compare process: flags, result and rd against the model on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!exp_active[i]) begin
          chk("idle_vld_bsy_rdy", i, {61'd0, v_o[i], bsy_o[i], rdy_o[i]}, 64'd1);
        end else if (cyc < exp_vcyc[i]) begin
          chk("busy_vld_bsy_rdy", i, {61'd0, v_o[i], bsy_o[i], rdy_o[i]}, 64'd2);
        end else begin
          chk("done_vld_bsy_rdy", i, {61'd0, v_o[i], bsy_o[i], rdy_o[i]}, 64'd6);
          chk("result", i, res_o[i], exp_res[i]);
          chk("rd", i, {59'd0, rd_out[i]}, {59'd0, exp_rd[i]});
        end
      end
    end
  end

  task automatic start_op(input int inst, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    @(negedge clk);
    op_i[inst] = op; a_i[inst] = a; b_i[inst] = b; rd_in[inst] = rd; v_i[inst] = 1'b1;
    @(posedge clk);
    #1;
    v_i[inst] = 1'b0;
    // scramble the inputs so the unit must rely on its latched copies
    a_i[inst] = ~a; b_i[inst] = ~b; rd_in[inst] = ~rd;
    exp_res[inst]    = model(op, a, b);
    exp_rd[inst]     = rd;
    exp_vcyc[inst]   = cyc + lat_of(inst, op, a, b);
    exp_active[inst] = 1'b1;
  endtask

  task automatic run_op(input int inst, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int hold,
                        input bit use_lit, input logic [63:0] lit);
    int target;
    start_op(inst, op, a, b, rd);
    target = exp_vcyc[inst] + hold;
    do @(negedge clk); while (cyc < target);
    if (use_lit) chk("literal_result", inst, res_o[inst], lit);
    rdy_i[inst] = 1'b1;
    @(posedge clk);
    #1;
    rdy_i[inst] = 1'b0;
    exp_active[inst] = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: rnd64 = 64'd0;
      1: rnd64 = ONES64;
      2: rnd64 = MIN64;
      3: rnd64 = 64'($urandom_range(0, 20));
      4: rnd64 = {32'($urandom), 32'h8000_0000};
      default: rnd64 = {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      v_i[i] = 1'b0; op_i[i] = 5'd0; a_i[i] = 64'd0; b_i[i] = 64'd0; rd_in[i] = 5'd0;
      fl_i[i] = 1'b0; rdy_i[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_vld_bsy_rdy", i, {61'd0, v_o[i], bsy_o[i], rdy_o[i]}, 64'd1);
      chk("reset_result", i, res_o[i], 64'd0);
      chk("reset_rd", i, {59'd0, rd_out[i]}, 64'd0);
    end
    rst_n = 1'b1;

    // directed values with hand-computed results
    run_op(0, OP_MUL,    ONES64, 64'd7,  5'd5,  0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op(0, OP_MULHU,  ONES64, ONES64, 5'd6,  0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(0, OP_MULH,   ONES64, ONES64, 5'd7,  0, 1'b1, 64'd0);
    run_op(0, OP_MULHSU, ONES64, 64'd2,  5'd8,  0, 1'b1, ONES64);
    run_op(0, OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(0, OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 0, 1'b1, ONES64);
    run_op(0, OP_DIVU,   64'd100, 64'd7, 5'd11, 0, 1'b1, 64'd14);
    run_op(0, OP_REMU,   64'd100, 64'd7, 5'd12, 0, 1'b1, 64'd2);
    for (int i = 0; i < 2; i++) begin
      run_op(i, OP_DIV,  64'd5, 64'd0, 5'd13, 0, 1'b1, ONES64);
      run_op(i, OP_REM,  64'd5, 64'd0, 5'd14, 0, 1'b1, 64'd5);
      run_op(i, OP_DIV,  MIN64, ONES64, 5'd15, 0, 1'b1, MIN64);
      run_op(i, OP_REM,  MIN64, ONES64, 5'd16, 0, 1'b1, 64'd0);
      run_op(i, OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd17, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(i, OP_MULW, 64'h1_0000, 64'h1_0000, 5'd18, 0, 1'b1, 64'd0);
      run_op(i, OP_REMW, 64'h0000_0000_8000_0000, ONES64, 5'd19, 0, 1'b1, 64'd0);
    end

    // backpressure: result held for 20 cycles in DONE
    run_op(0, OP_MUL, 64'd123456789, 64'd987654321, 5'd20, 20, 1'b1, 64'd121932631112635269);

    // non-M codes are ignored; flush beats a request in IDLE
    @(negedge clk); v_i[0] = 1'b1; op_i[0] = 5'd3;
    @(posedge clk); #1; op_i[0] = 5'd29;
    @(posedge clk); #1; op_i[0] = OP_DIV; fl_i[0] = 1'b1;
    @(posedge clk); #1; v_i[0] = 1'b0; fl_i[0] = 1'b0;

    // flush on cycle 10 of a DIV, then a normal op
    start_op(0, OP_DIV, 64'd1000, 64'd3, 5'd21);
    n = exp_vcyc[0] - 65 + 10;
    do @(negedge clk); while (cyc < n);
    fl_i[0] = 1'b1;
    @(posedge clk); #1;
    fl_i[0] = 1'b0;
    exp_active[0] = 1'b0;
    repeat (70) @(negedge clk);
    run_op(0, OP_DIVU, 64'd1000, 64'd3, 5'd22, 0, 1'b1, 64'd333);

    // flush a result in DONE while ready_i is high
    start_op(1, OP_MULW, 64'd3, 64'd4, 5'd23);
    n = exp_vcyc[1];
    do @(negedge clk); while (cyc < n);
    fl_i[1] = 1'b1; rdy_i[1] = 1'b1;
    @(posedge clk); #1;
    fl_i[1] = 1'b0; rdy_i[1] = 1'b0;
    exp_active[1] = 1'b0;

    // asynchronous reset in the middle of a MUL
    start_op(0, OP_MUL, 64'd77, 64'd99, 5'd24);
    n = exp_vcyc[0] - 40;
    do @(negedge clk); while (cyc < n);
    #2;
    rst_n = 1'b0;
    exp_active[0] = 1'b0;
    #1;
    chk("midreset_vld_bsy_rdy", 0, {61'd0, v_o[0], bsy_o[0], rdy_o[0]}, 64'd1);
    chk("midreset_result", 0, res_o[0], 64'd0);
    chk("midreset_rd", 0, {59'd0, rd_out[0]}, 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // randomized ops on both variants
    for (int k = 0; k < 36; k++) begin
      int inst;
      logic [4:0] op;
      inst = int'($urandom_range(0, 1));
      op = OP_MUL + 5'($urandom_range(0, 12));
      run_op(inst, op, rnd64(), rnd64(), 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), 1'b0, 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
